// File: rtl/instruction_fetch_unit_pkg.sv
// Shared processor definitions for the fetch stage.
// Holds the fetch state encoding, the default halt encoding and the NOP word.
package instruction_fetch_unit_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_WORD          = 32'h0000_0000;
    localparam logic [31:0] PC_ALIGN_MASK     = 32'hFFFF_FFFC;
    localparam logic [31:0] PC_STEP           = 32'd4;

endpackage

// File: rtl/instruction_fetch_unit_if_id_register.sv
// IF/ID pipeline register: holds the fetched word and its PC+4 for decode.
// Priority is Reset > clear > load; with neither clear nor load it holds.
import instruction_fetch_unit_pkg::*;

module if_id_register (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        i_load,
    input  logic        i_clear,
    input  logic [31:0] i_instruction,
    input  logic [31:0] i_pcPlus4,
    output logic [31:0] o_instruction,
    output logic [31:0] o_pcPlus4,
    output logic        o_valid
);

    logic [31:0] r_instruction;
    logic [31:0] r_pcPlus4;
    logic        r_valid;

    // A clear turns the stage into a bubble holding the NOP encoding.
    always_ff @(posedge Clk) begin
        if (Reset || i_clear) begin
            r_instruction <= NOP_WORD;
            r_pcPlus4     <= 32'd0;
            r_valid       <= 1'b0;
        end else if (i_load) begin
            r_instruction <= i_instruction;
            r_pcPlus4     <= i_pcPlus4;
            r_valid       <= 1'b1;
        end
    end

    assign o_instruction = r_instruction;
    assign o_pcPlus4     = r_pcPlus4;
    assign o_valid       = r_valid;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: drives the PC to instruction memory, feeds IF/ID,
// and handles stall, redirect and halt-on-HALT_WORD.
import instruction_fetch_unit_pkg::*;

module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic [31:0] ImemAddress,
    input  logic [31:0] ImemInstruction,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectTarget,
    output logic [31:0] IfIdInstruction,
    output logic [31:0] IfIdPCPlus4,
    output logic        IfIdValid,
    output logic        Halted,
    output logic [31:0] FetchCount
);

    fetch_state_t r_state;
    fetch_state_t w_stateNext;
    logic [31:0]  r_pc;
    logic [31:0]  w_pcNext;
    logic [31:0]  w_pcPlus4;
    logic [31:0]  r_fetchCount;
    logic [31:0]  w_fetchCountNext;
    logic         w_ifIdLoad;
    logic         w_ifIdClear;

    assign w_pcPlus4 = r_pc + PC_STEP;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= RUN;
            r_pc         <= RESET_PC & PC_ALIGN_MASK;
            r_fetchCount <= 32'd0;
        end else begin
            r_state      <= w_stateNext;
            r_pc         <= w_pcNext;
            r_fetchCount <= w_fetchCountNext;
        end
    end

    // Redirect beats Stall; the halt check only applies on a normal advance.
    always_comb begin
        w_stateNext      = r_state;
        w_pcNext         = r_pc;
        w_fetchCountNext = r_fetchCount;
        w_ifIdLoad       = 1'b0;
        w_ifIdClear      = 1'b0;
        case (r_state)
            RUN: begin
                if (Redirect) begin
                    w_pcNext    = RedirectTarget & PC_ALIGN_MASK;
                    w_ifIdClear = 1'b1;
                end else if (Stall) begin
                    w_pcNext = r_pc;
                end else if (ImemInstruction == HALT_WORD) begin
                    w_stateNext = HALTED;
                    w_ifIdClear = 1'b1;
                end else begin
                    w_pcNext         = w_pcPlus4;
                    w_ifIdLoad       = 1'b1;
                    w_fetchCountNext = r_fetchCount + 32'd1;
                end
            end
            HALTED: begin
                w_stateNext = HALTED;
            end
            default: begin
                w_stateNext = RUN;
            end
        endcase
    end

    if_id_register u_ifIdRegister (
        .Clk           (Clk),
        .Reset         (Reset),
        .i_load        (w_ifIdLoad),
        .i_clear       (w_ifIdClear),
        .i_instruction (ImemInstruction),
        .i_pcPlus4     (w_pcPlus4),
        .o_instruction (IfIdInstruction),
        .o_pcPlus4     (IfIdPCPlus4),
        .o_valid       (IfIdValid)
    );

    assign ImemAddress = r_pc;
    assign Halted      = (r_state == HALTED);
    assign FetchCount  = r_fetchCount;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; instruction memory is modelled
// as word i = i*3, with an optional HALT_WORD planted at address 0x20.
module tb_instruction_fetch_unit;

    logic        Clk;
    logic        Reset;
    logic [31:0] ImemAddress;
    logic [31:0] ImemInstruction;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectTarget;
    logic [31:0] IfIdInstruction;
    logic [31:0] IfIdPCPlus4;
    logic        IfIdValid;
    logic        Halted;
    logic [31:0] FetchCount;

    logic        resetB;
    logic [31:0] imemAddressB;
    logic [31:0] imemInstructionB;
    logic [31:0] ifIdInstructionB;
    logic [31:0] ifIdPCPlus4B;
    logic        ifIdValidB;
    logic        haltedB;
    logic [31:0] fetchCountB;

    logic        haltEnable;
    int          checkCount;
    int          passCount;

    function automatic logic [31:0] memWord(input logic [31:0] addr, input logic useHalt);
        logic [31:0] index;
        index = addr >> 2;
        if (useHalt && addr == 32'h20) return 32'hFFFF_FFFF;
        return index * 32'd3;
    endfunction

    assign ImemInstruction  = memWord(ImemAddress, haltEnable);
    assign imemInstructionB = memWord(imemAddressB, 1'b0);

    instruction_fetch_unit dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .ImemAddress     (ImemAddress),
        .ImemInstruction (ImemInstruction),
        .Stall           (Stall),
        .Redirect        (Redirect),
        .RedirectTarget  (RedirectTarget),
        .IfIdInstruction (IfIdInstruction),
        .IfIdPCPlus4     (IfIdPCPlus4),
        .IfIdValid       (IfIdValid),
        .Halted          (Halted),
        .FetchCount      (FetchCount)
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
        .Clk             (Clk),
        .Reset           (resetB),
        .ImemAddress     (imemAddressB),
        .ImemInstruction (imemInstructionB),
        .Stall           (1'b0),
        .Redirect        (1'b0),
        .RedirectTarget  (32'h0),
        .IfIdInstruction (ifIdInstructionB),
        .IfIdPCPlus4     (ifIdPCPlus4B),
        .IfIdValid       (ifIdValidB),
        .Halted          (haltedB),
        .FetchCount      (fetchCountB)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    endtask

    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic doReset();
        Reset = 1'b1;
        applyStimulus(1);
        Reset = 1'b0;
    endtask

    initial begin
        checkCount     = 0;
        passCount      = 0;
        Reset          = 1'b1;
        resetB         = 1'b1;
        Stall          = 1'b0;
        Redirect       = 1'b0;
        RedirectTarget = 32'h0;
        haltEnable     = 1'b0;

        // Reset state and basic fetch stream
        applyStimulus(1);
        checkOutput("rst_addr", ImemAddress, 32'h0);
        checkOutput("rst_valid", {31'd0, IfIdValid}, 32'd0);
        checkOutput("rst_instr", IfIdInstruction, 32'h0);
        checkOutput("rst_count", FetchCount, 32'd0);
        checkOutput("rst_halted", {31'd0, Halted}, 32'd0);
        Reset = 1'b0;
        applyStimulus(1);
        checkOutput("adv1_addr", ImemAddress, 32'h4);
        checkOutput("adv1_instr", IfIdInstruction, 32'd0);
        checkOutput("adv1_pc4", IfIdPCPlus4, 32'h4);
        checkOutput("adv1_valid", {31'd0, IfIdValid}, 32'd1);
        applyStimulus(1);
        checkOutput("adv2_addr", ImemAddress, 32'h8);
        checkOutput("adv2_instr", IfIdInstruction, 32'd3);
        checkOutput("adv2_pc4", IfIdPCPlus4, 32'h8);
        applyStimulus(1);
        checkOutput("adv3_addr", ImemAddress, 32'hC);
        checkOutput("adv3_instr", IfIdInstruction, 32'd6);
        checkOutput("adv3_pc4", IfIdPCPlus4, 32'hC);
        checkOutput("adv3_count", FetchCount, 32'd3);

        // Stall at PC=8 for two cycles
        doReset();
        applyStimulus(2);
        Stall = 1'b1;
        applyStimulus(2);
        checkOutput("stall_addr", ImemAddress, 32'h8);
        checkOutput("stall_instr", IfIdInstruction, 32'd3);
        checkOutput("stall_pc4", IfIdPCPlus4, 32'h8);
        checkOutput("stall_valid", {31'd0, IfIdValid}, 32'd1);
        checkOutput("stall_count", FetchCount, 32'd2);
        Stall = 1'b0;
        applyStimulus(1);
        checkOutput("unstall_addr", ImemAddress, 32'hC);
        checkOutput("unstall_instr", IfIdInstruction, 32'd6);
        checkOutput("unstall_count", FetchCount, 32'd3);

        // Redirect with Stall at PC=16 to an unaligned target
        applyStimulus(1);
        checkOutput("pre_redir_addr", ImemAddress, 32'h10);
        Redirect       = 1'b1;
        Stall          = 1'b1;
        RedirectTarget = 32'h0000_0043;
        applyStimulus(1);
        checkOutput("redir_addr", ImemAddress, 32'h40);
        checkOutput("redir_valid", {31'd0, IfIdValid}, 32'd0);
        checkOutput("redir_instr", IfIdInstruction, 32'h0);
        checkOutput("redir_count", FetchCount, 32'd4);
        Redirect = 1'b0;
        Stall    = 1'b0;
        applyStimulus(1);
        checkOutput("post_redir_instr", IfIdInstruction, 32'd48);
        checkOutput("post_redir_pc4", IfIdPCPlus4, 32'h44);
        checkOutput("post_redir_valid", {31'd0, IfIdValid}, 32'd1);
        checkOutput("post_redir_count", FetchCount, 32'd5);

        // Halt word at 0x20: ignored while stalled, then halts
        haltEnable = 1'b1;
        doReset();
        applyStimulus(8);
        checkOutput("pre_halt_addr", ImemAddress, 32'h20);
        checkOutput("pre_halt_instr", IfIdInstruction, 32'd21);
        Stall = 1'b1;
        applyStimulus(1);
        checkOutput("stall_halt_flag", {31'd0, Halted}, 32'd0);
        Stall = 1'b0;
        applyStimulus(1);
        checkOutput("halt_flag", {31'd0, Halted}, 32'd1);
        checkOutput("halt_addr", ImemAddress, 32'h20);
        checkOutput("halt_valid", {31'd0, IfIdValid}, 32'd0);
        checkOutput("halt_count", FetchCount, 32'd8);
        Redirect       = 1'b1;
        RedirectTarget = 32'h0;
        applyStimulus(2);
        checkOutput("halt_redir_addr", ImemAddress, 32'h20);
        checkOutput("halt_redir_flag", {31'd0, Halted}, 32'd1);
        Reset = 1'b1;
        applyStimulus(1);
        Reset    = 1'b0;
        Redirect = 1'b0;
        checkOutput("unhalt_addr", ImemAddress, 32'h0);
        checkOutput("unhalt_flag", {31'd0, Halted}, 32'd0);
        haltEnable = 1'b0;

        // PC wrap from RESET_PC = 0xFFFF_FFFC
        resetB = 1'b1;
        applyStimulus(1);
        checkOutput("wrap_rst_addr", imemAddressB, 32'hFFFF_FFFC);
        resetB = 1'b0;
        applyStimulus(1);
        checkOutput("wrap_addr", imemAddressB, 32'h0);
        checkOutput("wrap_pc4", ifIdPCPlus4B, 32'h0);
        checkOutput("wrap_instr", ifIdInstructionB, 32'hBFFF_FFFD);
        applyStimulus(1);
        checkOutput("wrap2_addr", imemAddressB, 32'h4);
        checkOutput("wrap2_count", fetchCountB, 32'd2);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
